control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that replaces hand-driven T-state stimulus for `datapath`.
- Fetches instructions, decodes IR[31:27], and steps the datapath through each instruction's T-states.
- Drives every bus-out, register-in, ALU-select and memory strobe that `datapath` exposes.
- Covers R-type ALU, immediate ALU, ldi/ld/st, conditional branch, nop and halt.

Parameters:
- OPW, 5, opcode and ALU `operation` width.
- MEM_WAIT, 0, extra cycles Read/Write are held in the memory states (0..7).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; state forced to S_RESET.
- opcode  in  OPW  IR[31:27] from IR register.
- CON_out  in  1  branch condition flag from CON FF.
- PCout, Zlowout, MDRout, Cout, BAout, Rout  out  1 each  bus drivers.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CON_in  out  1 each  register loads.
- Gra, Grb, Grc  out  1 each  IR register-field selects.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- operation  out  OPW  ALU function select.
- Run  out  1  high while executing; low in S_RESET and S_HALT.

Behaviour:
- Outputs decode from the state register only (Moore). Any signal not listed for a state is 0; `operation` defaults to 0.
- Reset high at an edge:
  - state goes to S_RESET from any state, mid-instruction included, and the wait counter clears.
  - In S_RESET all outputs are 0, Run=0. First edge with Reset low moves to T0.
- Fetch:
  - T0: PCout, MARin.
  - T1: Read, MDRin, IncPC, PCin.
  - T2: MDRout, IRin.
  - T3 (decode) is the first class-specific state.
- Read/Write states dwell MEM_WAIT+1 cycles via a 3-bit counter: loaded at entry, advance when the counter is 0. Strobes stay high for the whole dwell.
- Opcodes and sequences (package constants). The sequence ends at the last state listed and the next state is T0.
  - R-type add 00011, sub 00100, and 00101, or 00110:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, operation=opcode.
    - T5: Zlowout, Gra, Rin.
  - Immediate addi 01100, andi 01101, ori 01110:
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, operation = ADD 00011 / AND 00101 / OR 00110 respectively.
    - T5: Zlowout, Gra, Rin.
  - ldi 00001:
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, operation=00011.
    - T5: Zlowout, Gra, Rin.
  - ld 00000:
    - T3–T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin (waited).
    - T7: MDRout, Gra, Rin.
  - st 00010:
    - T3–T5 as ld.
    - T6: Gra, Rout, MDRin (Read=0).
    - T7: Write (waited).
  - br 10010:
    - T3: Gra, Rout, CON_in.
    - T4: PCout, Yin.
    - T5: Cout, Zin, operation=00011.
    - T6: if CON_out sampled in T6 is high, Zlowout and PCin; otherwise no strobes.
  - nop 11010 and any undefined opcode: T3 has no strobes; next state is T0.
  - halt 11011: goes to S_HALT. Outputs 0, Run=0. Stays there until Reset.
- Mutual exclusion: at most one bus driver is high in any state. The bench asserts this every cycle.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - opcode localparams;
  - ALU codes ALU_ADD=00011, ALU_SUB=00100, ALU_AND=00101, ALU_OR=00110;
  - state encoding (S_RESET, T0..T7 per class, S_HALT).
- Sub-module `mem_wait_ctr` holds the 3-bit dwell counter with load/done. All other logic stays in one next-state block and one output-decode block.

Test Plan:
- Reset held 3 cycles, then released → S_RESET, all outputs 0, Run=0; next cycle T0 with PCout=MARin=1, Run=1.
- opcode=01110 (ori) → T3 Grb/Rout/Yin; T4 Cout/Zin with operation=00110; T5 Zlowout/Gra/Rin; next T0. Total 6 cycles.
- opcode=00000 (ld), MEM_WAIT=2 → T1 Read high 3 cycles; T6 Read/MDRin high 3 cycles; T7 MDRout/Gra/Rin. Total 12 cycles.
- opcode=10010 (br):
  - CON_out=1 → PCin/Zlowout high in T6.
  - Repeat with CON_out=0 → no strobes in T6. Both return to T0.
- Reset asserted during st T6 → next edge S_RESET; Write never asserted; refetch starts at T0.
- opcode=11011 (halt) → S_HALT, Run=0 for 20 cycles regardless of inputs; Reset recovers. opcode=11111 behaves as nop.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes, sequencer state encoding and decode helpers
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2,
    S_R3, S_R4, S_R5,
    S_I3, S_I4, S_I5,
    S_LI3, S_LI4, S_LI5,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
    S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
    S_BR3, S_BR4, S_BR5, S_BR6,
    S_NOP3, S_HALT
  } state_t;
  function automatic logic is_wait(input state_t s);
    return s == S_T1 || s == S_LD6 || s == S_ST7;
  endfunction
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    return op == OP_ADDI ? ALU_ADD : op == OP_ANDI ? ALU_AND : ALU_OR;
  endfunction
  function automatic state_t decode(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return S_R3;
      OP_ADDI, OP_ANDI, OP_ORI:      return S_I3;
      OP_LDI:                        return S_LI3;
      OP_LD:                         return S_LD3;
      OP_ST:                         return S_ST3;
      OP_BR:                         return S_BR3;
      OP_HALT:                       return S_HALT;
      default:                       return S_NOP3;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: 3-bit dwell counter holding memory strobes for MEM_WAIT+1 cycles
module mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  output logic done
);
  logic [2:0] cnt;
  always_ff @(posedge Clock) begin
    if (Reset) cnt <= '0;
    else if (load) cnt <= 3'(MEM_WAIT);
    else if (!done) cnt <= cnt - 3'd1;
  end
  assign done = cnt == 3'd0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping the datapath through fetch and execute T-states
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW      = 5,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           CON_out,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Cout,
  output logic           BAout,
  output logic           Rout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Rin,
  output logic           CON_in,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] operation,
  output logic           Run
);
  state_t state, state_next;
  logic [OPW-1:0] op_q;
  logic ctr_load, done;
  assign ctr_load = !is_wait(state);
  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_ctr (
    .Clock(Clock),
    .Reset(Reset),
    .load (ctr_load),
    .done (done)
  );
  // opcode is captured as IR loads so T4 ALU selects stay a function of registered state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_RESET;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_T2) op_q <= opcode;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = done ? S_T2 : S_T1;
      S_T2:    state_next = decode(opcode);
      S_R3:    state_next = S_R4;
      S_R4:    state_next = S_R5;
      S_I3:    state_next = S_I4;
      S_I4:    state_next = S_I5;
      S_LI3:   state_next = S_LI4;
      S_LI4:   state_next = S_LI5;
      S_LD3:   state_next = S_LD4;
      S_LD4:   state_next = S_LD5;
      S_LD5:   state_next = S_LD6;
      S_LD6:   state_next = done ? S_LD7 : S_LD6;
      S_ST3:   state_next = S_ST4;
      S_ST4:   state_next = S_ST5;
      S_ST5:   state_next = S_ST6;
      S_ST6:   state_next = S_ST7;
      S_ST7:   state_next = done ? S_T0 : S_ST7;
      S_BR3:   state_next = S_BR4;
      S_BR4:   state_next = S_BR5;
      S_BR5:   state_next = S_BR6;
      S_HALT:  state_next = S_HALT;
      S_R5, S_I5, S_LI5, S_LD7, S_BR6, S_NOP3: state_next = S_T0;
      default: state_next = S_RESET;
    endcase
  end
  always_comb begin
    {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CON_in} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    operation = '0;
    Run = state != S_RESET && state != S_HALT;
    case (state)
      S_T0:                 {PCout, MARin} = '1;
      S_T1:                 {Read, MDRin, IncPC, PCin} = '1;
      S_T2:                 {MDRout, IRin} = '1;
      S_R3, S_I3:           {Grb, Rout, Yin} = '1;
      S_LI3, S_LD3, S_ST3:  {Grb, BAout, Yin} = '1;
      S_R5, S_I5, S_LI5:    {Zlowout, Gra, Rin} = '1;
      S_LD5, S_ST5:         {Zlowout, MARin} = '1;
      S_LD6:                {Read, MDRin} = '1;
      S_LD7:                {MDRout, Gra, Rin} = '1;
      S_ST6:                {Gra, Rout, MDRin} = '1;
      S_ST7:                Write = 1'b1;
      S_BR3:                {Gra, Rout, CON_in} = '1;
      S_BR4:                {PCout, Yin} = '1;
      S_BR6:                {Zlowout, PCin} = {2{CON_out}};
      S_R4: begin
        {Grc, Rout, Zin} = '1;
        operation = op_q;
      end
      S_I4: begin
        {Cout, Zin} = '1;
        operation = imm_alu(op_q);
      end
      S_LI4, S_LD4, S_ST4, S_BR5: begin
        {Cout, Zin} = '1;
        operation = ALU_ADD;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of two sequencers (MEM_WAIT 0 and 2) sharing stimulus
module tb_control_sequencer;
  localparam logic [20:0] PCO  = 21'd1 << 20;
  localparam logic [20:0] ZLO  = 21'd1 << 19;
  localparam logic [20:0] MDRO = 21'd1 << 18;
  localparam logic [20:0] CO   = 21'd1 << 17;
  localparam logic [20:0] BAO  = 21'd1 << 16;
  localparam logic [20:0] RO   = 21'd1 << 15;
  localparam logic [20:0] MARI = 21'd1 << 14;
  localparam logic [20:0] ZI   = 21'd1 << 13;
  localparam logic [20:0] PCI  = 21'd1 << 12;
  localparam logic [20:0] MDRI = 21'd1 << 11;
  localparam logic [20:0] IRI  = 21'd1 << 10;
  localparam logic [20:0] YI   = 21'd1 << 9;
  localparam logic [20:0] RI   = 21'd1 << 8;
  localparam logic [20:0] CONI = 21'd1 << 7;
  localparam logic [20:0] GRA  = 21'd1 << 6;
  localparam logic [20:0] GRB  = 21'd1 << 5;
  localparam logic [20:0] GRC  = 21'd1 << 4;
  localparam logic [20:0] INC  = 21'd1 << 3;
  localparam logic [20:0] RD   = 21'd1 << 2;
  localparam logic [20:0] WR   = 21'd1 << 1;
  localparam logic [20:0] RUN  = 21'd1;
  localparam logic [20:0] E_T0 = PCO | MARI | RUN;
  localparam logic [20:0] E_T1 = RD | MDRI | INC | PCI | RUN;
  localparam logic [20:0] E_T2 = MDRO | IRI | RUN;
  logic Clock = 1'b0, Reset = 1'b1, CON_out = 1'b0, wrote = 1'b0;
  logic [4:0] opcode = 5'b01110;
  logic [20:0] s0, s2;
  logic [4:0] op0, op2;
  int passed = 0, total = 0;
  always #5 Clock = ~Clock;
  control_sequencer #(.OPW(5), .MEM_WAIT(0)) d0 (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .CON_out(CON_out),
    .PCout(s0[20]), .Zlowout(s0[19]), .MDRout(s0[18]), .Cout(s0[17]), .BAout(s0[16]), .Rout(s0[15]),
    .MARin(s0[14]), .Zin(s0[13]), .PCin(s0[12]), .MDRin(s0[11]), .IRin(s0[10]), .Yin(s0[9]),
    .Rin(s0[8]), .CON_in(s0[7]), .Gra(s0[6]), .Grb(s0[5]), .Grc(s0[4]), .IncPC(s0[3]),
    .Read(s0[2]), .Write(s0[1]), .operation(op0), .Run(s0[0])
  );
  control_sequencer #(.OPW(5), .MEM_WAIT(2)) d2 (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .CON_out(CON_out),
    .PCout(s2[20]), .Zlowout(s2[19]), .MDRout(s2[18]), .Cout(s2[17]), .BAout(s2[16]), .Rout(s2[15]),
    .MARin(s2[14]), .Zin(s2[13]), .PCin(s2[12]), .MDRin(s2[11]), .IRin(s2[10]), .Yin(s2[9]),
    .Rin(s2[8]), .CON_in(s2[7]), .Gra(s2[6]), .Grb(s2[5]), .Grc(s2[4]), .IncPC(s2[3]),
    .Read(s2[2]), .Write(s2[1]), .operation(op2), .Run(s2[0])
  );
  task automatic step();
    @(posedge Clock);
    #1;
    wrote = wrote | s2[1];
    total++;
    assert ($onehot0(s0[20:15]) && $onehot0(s2[20:15])) passed++;
    else $error("FAIL bus_excl: got d0=%b d2=%b, want at most one driver", s0[20:15], s2[20:15]);
  endtask
  task automatic chk(input string tag, input bit slow, input logic [20:0] exp, input logic [4:0] eop);
    logic [20:0] s;
    logic [4:0] o;
    s = slow ? s2 : s0;
    o = slow ? op2 : op0;
    total++;
    assert (s === exp && o === eop) passed++;
    else $error("FAIL %s: got sig=%h op=%b, want sig=%h op=%b", tag, s, o, exp, eop);
  endtask
  initial begin
    repeat (3) step();
    chk("reset_d0", 0, '0, '0);
    chk("reset_d2", 1, '0, '0);
    Reset = 1'b0;
    step(); chk("t0_d0", 0, E_T0, '0); chk("t0_d2", 1, E_T0, '0);
    step(); chk("ori_t1", 0, E_T1, '0);
    step(); chk("ori_t2", 0, E_T2, '0);
    step(); chk("ori_t3", 0, GRB | RO | YI | RUN, '0);
    step(); chk("ori_t4", 0, CO | ZI | RUN, 5'b00110);
    step(); chk("ori_t5", 0, ZLO | GRA | RI | RUN, '0);
    step(); chk("ori_t0", 0, E_T0, '0);
    Reset = 1'b1;
    step(); chk("ld_rst", 1, '0, '0);
    Reset = 1'b0; opcode = 5'b00000;
    step(); chk("ld_t0", 1, E_T0, '0);
    for (int i = 0; i < 3; i++) begin step(); chk("ld_t1", 1, E_T1, '0); end
    step(); chk("ld_t2", 1, E_T2, '0);
    step(); chk("ld_t3", 1, GRB | BAO | YI | RUN, '0);
    step(); chk("ld_t4", 1, CO | ZI | RUN, 5'b00011);
    step(); chk("ld_t5", 1, ZLO | MARI | RUN, '0);
    for (int i = 0; i < 3; i++) begin step(); chk("ld_t6", 1, RD | MDRI | RUN, '0); end
    step(); chk("ld_t7", 1, MDRO | GRA | RI | RUN, '0);
    step(); chk("ld_end", 1, E_T0, '0);
    opcode = 5'b10010;
    for (int c = 1; c >= 0; c--) begin
      CON_out = c[0];
      for (int i = 0; i < 3; i++) begin step(); chk("br_t1", 1, E_T1, '0); end
      step(); chk("br_t2", 1, E_T2, '0);
      step(); chk("br_t3", 1, GRA | RO | CONI | RUN, '0);
      step(); chk("br_t4", 1, PCO | YI | RUN, '0);
      step(); chk("br_t5", 1, CO | ZI | RUN, 5'b00011);
      step(); chk(c[0] ? "br_t6_taken" : "br_t6_not", 1, c[0] ? (ZLO | PCI | RUN) : RUN, '0);
      step(); chk("br_end", 1, E_T0, '0);
    end
    opcode = 5'b00010;
    wrote = 1'b0;
    repeat (7) step();
    chk("st_t5", 1, ZLO | MARI | RUN, '0);
    step(); chk("st_t6", 1, GRA | RO | MDRI | RUN, '0);
    Reset = 1'b1;
    step(); chk("st_abort", 1, '0, '0);
    Reset = 1'b0;
    step(); chk("st_refetch", 1, E_T0, '0);
    total++;
    assert (wrote === 1'b0) passed++;
    else $error("FAIL st_no_write: got wrote=%b, want 0", wrote);
    opcode = 5'b11011;
    repeat (6) step();
    for (int i = 0; i < 20; i++) begin
      opcode = 5'(i * 7);
      CON_out = i[0];
      step();
      chk("halt_d0", 0, '0, '0);
      chk("halt_d2", 1, '0, '0);
    end
    opcode = 5'b11111;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step(); chk("halt_recover", 0, E_T0, '0);
    step(); step();
    step(); chk("nop_t3", 0, RUN, '0);
    step(); chk("nop_end", 0, E_T0, '0);
    opcode = 5'b00100;
    step(); step();
    step(); chk("sub_t3", 0, GRB | RO | YI | RUN, '0);
    step(); chk("sub_t4", 0, GRC | RO | ZI | RUN, 5'b00100);
    step(); chk("sub_t5", 0, ZLO | GRA | RI | RUN, '0);
    step(); chk("sub_end", 0, E_T0, '0);
    opcode = 5'b00010;
    step(); step();
    step(); chk("st0_t3", 0, GRB | BAO | YI | RUN, '0);
    step(); chk("st0_t4", 0, CO | ZI | RUN, 5'b00011);
    step(); chk("st0_t5", 0, ZLO | MARI | RUN, '0);
    step(); chk("st0_t6", 0, GRA | RO | MDRI | RUN, '0);
    step(); chk("st0_t7", 0, WR | RUN, '0);
    step(); chk("st0_end", 0, E_T0, '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
